fetch_pc_unit: RTL and testbench

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

---
 rtl/pc_pkg.sv | 25 ++
 rtl/redirect_hold_reg.sv | 26 ++
 rtl/fetch_pc_unit.sv | 122 ++++++++++++
 tb/tb_fetch_pc_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared encodings for the fetch PC unit: redirect kinds, FSM states and the
// sequential increment, plus the redirect legality check.
package pc_pkg;

    typedef enum logic [1:0] {
        KIND_BRANCH = 2'd0,
        KIND_JR     = 2'd1,
        KIND_JUMP   = 2'd2,
        KIND_RSVD   = 2'd3
    } redirect_kind_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_INCR = 32'd4;

    // A redirect is illegal when it is not word aligned or uses the reserved kind.
    function automatic logic redirect_is_bad(input logic [1:0] kind, input logic [1:0] tgt_lsb);
        return (tgt_lsb != 2'b00) || (redirect_kind_e'(kind) == KIND_RSVD);
    endfunction

endpackage

// File: rtl/redirect_hold_reg.sv
// Pending-redirect buffer: one valid bit plus a 32-bit target.
// A load overwrites any held target; load wins over clear in the same cycle.
module redirect_hold_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] target,
    output logic        pending,
    output logic [31:0] pending_target
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending        <= 1'b0;
            pending_target <= 32'h0;
        end else if (load) begin
            pending        <= 1'b1;
            pending_target <= target;
        end else if (clear) begin
            pending        <= 1'b0;
            pending_target <= 32'h0;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator with IF/ID register, stall-deferred redirects,
// illegal-redirect fault capture and a saturating redirect counter.
module fetch_pc_unit
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Stall,
    input  logic             RedirectValid,
    input  logic [1:0]       RedirectKind,
    input  logic [31:0]      RedirectTarget,
    input  logic             FaultClear,
    output logic [31:0]      PC,
    output logic [31:0]      IFID_PC,
    output logic [31:0]      IFID_PCPlus4,
    output logic             IFID_Valid,
    output logic             Fault,
    output logic [31:0]      FaultAddr,
    output logic [CNT_W-1:0] RedirectCount
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    fetch_state_e      state, state_next;
    logic [31:0]       pc_next, ifid_pc_next, ifid_pc4_next, fault_addr_next;
    logic              ifid_valid_next, fault_next;
    logic [CNT_W-1:0]  count_next;
    logic              hold_load, hold_clear;
    logic              pending;
    logic [31:0]       pending_target;
    logic              redirect_bad;

    redirect_hold_reg u_hold (
        .clk            (Clk),
        .rst_n          (Reset_n),
        .load           (hold_load),
        .clear          (hold_clear),
        .target         (RedirectTarget),
        .pending        (pending),
        .pending_target (pending_target)
    );

    assign redirect_bad = RedirectValid && redirect_is_bad(RedirectKind, RedirectTarget[1:0]);

    always_comb begin
        state_next      = state;
        pc_next         = PC;
        ifid_pc_next    = IFID_PC;
        ifid_pc4_next   = IFID_PCPlus4;
        ifid_valid_next = IFID_Valid;
        fault_next      = Fault;
        fault_addr_next = FaultAddr;
        count_next      = RedirectCount;
        hold_load       = 1'b0;
        hold_clear      = 1'b0;

        case (state)
            ST_RUN, ST_PEND: begin
                if (redirect_bad) begin
                    state_next      = ST_FAULT;
                    fault_next      = 1'b1;
                    fault_addr_next = RedirectTarget;
                    ifid_valid_next = 1'b0;
                    hold_clear      = 1'b1;
                end else if (RedirectValid && Stall) begin
                    // Youngest redirect overwrites whatever is already buffered.
                    hold_load  = 1'b1;
                    state_next = ST_PEND;
                end else if (!Stall) begin
                    if (RedirectValid || pending) begin
                        pc_next         = RedirectValid ? RedirectTarget : pending_target;
                        ifid_valid_next = 1'b0;
                        count_next      = sat_inc(RedirectCount);
                        hold_clear      = 1'b1;
                        state_next      = ST_RUN;
                    end else begin
                        pc_next         = PC + PC_INCR;
                        ifid_pc_next    = PC;
                        ifid_pc4_next   = PC + PC_INCR;
                        ifid_valid_next = 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                if (FaultClear) begin
                    pc_next    = RESET_PC;
                    fault_next = 1'b0;
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= ST_RUN;
            PC            <= RESET_PC;
            IFID_PC       <= 32'h0;
            IFID_PCPlus4  <= 32'h0;
            IFID_Valid    <= 1'b0;
            Fault         <= 1'b0;
            FaultAddr     <= 32'h0;
            RedirectCount <= '0;
        end else begin
            state         <= state_next;
            PC            <= pc_next;
            IFID_PC       <= ifid_pc_next;
            IFID_PCPlus4  <= ifid_pc4_next;
            IFID_Valid    <= ifid_valid_next;
            Fault         <= fault_next;
            FaultAddr     <= fault_addr_next;
            RedirectCount <= count_next;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the fetch rules.
module tb_fetch_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          CNT_W    = 4;
    localparam logic [31:0] CNT_MAX  = (32'd1 << CNT_W) - 32'd1;

    logic             Clk;
    logic             Reset_n;
    logic             Stall;
    logic             RedirectValid;
    logic [1:0]       RedirectKind;
    logic [31:0]      RedirectTarget;
    logic             FaultClear;
    logic [31:0]      PC;
    logic [31:0]      IFID_PC;
    logic [31:0]      IFID_PCPlus4;
    logic             IFID_Valid;
    logic             Fault;
    logic [31:0]      FaultAddr;
    logic [CNT_W-1:0] RedirectCount;

    fetch_pc_unit #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .Stall          (Stall),
        .RedirectValid  (RedirectValid),
        .RedirectKind   (RedirectKind),
        .RedirectTarget (RedirectTarget),
        .FaultClear     (FaultClear),
        .PC             (PC),
        .IFID_PC        (IFID_PC),
        .IFID_PCPlus4   (IFID_PCPlus4),
        .IFID_Valid     (IFID_Valid),
        .Fault          (Fault),
        .FaultAddr      (FaultAddr),
        .RedirectCount  (RedirectCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_pc, m_ifid_pc, m_ifid_pc4, m_faddr, m_ptgt;
    logic        m_valid, m_faulted, m_has_pend;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_ifid_pc = 0; m_ifid_pc4 = 0; m_valid = 0;
        m_faulted = 0; m_faddr = 0; m_cnt = 0; m_has_pend = 0; m_ptgt = 0;
    endtask

    task automatic model_step();
        bit bad;
        bad = RedirectValid && ((RedirectTarget[1:0] != 2'b00) || (RedirectKind == 2'd3));
        if (m_faulted) begin
            if (FaultClear) begin
                m_pc = RESET_PC;
                m_faulted = 0;
            end
        end else if (bad) begin
            m_faulted = 1; m_faddr = RedirectTarget; m_valid = 0; m_has_pend = 0;
        end else begin
            if (RedirectValid) begin
                m_has_pend = 1; m_ptgt = RedirectTarget;
            end
            if (!Stall) begin
                if (m_has_pend) begin
                    m_pc = m_ptgt; m_valid = 0; m_has_pend = 0;
                    if (m_cnt < int'(CNT_MAX)) m_cnt++;
                end else begin
                    m_ifid_pc = m_pc; m_ifid_pc4 = m_pc + 32'd4; m_valid = 1;
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    PC,                  m_pc);
        chk({tag, ".ifpc"},  IFID_PC,             m_ifid_pc);
        chk({tag, ".ifpc4"}, IFID_PCPlus4,        m_ifid_pc4);
        chk({tag, ".ifvld"}, 32'(IFID_Valid),     32'(m_valid));
        chk({tag, ".fault"}, 32'(Fault),          32'(m_faulted));
        chk({tag, ".faddr"}, FaultAddr,           m_faddr);
        chk({tag, ".cnt"},   32'(RedirectCount),  32'(m_cnt));
    endtask

    task automatic set_in(input logic st, input logic rv, input logic [1:0] kind,
                          input logic [31:0] tgt, input logic fc);
        Stall = st; RedirectValid = rv; RedirectKind = kind; RedirectTarget = tgt; FaultClear = fc;
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge Clk);
        #1;
        check_all(tag);
        @(negedge Clk);
    endtask

    task automatic apply_reset();
        Reset_n = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    initial begin
        set_in(0, 0, 2'd0, 32'h0, 0);
        apply_reset();

        // Sequential fetch out of reset
        chk("seq.pc0", PC, 32'h0);
        step("seq1"); chk("seq.pc1", PC, 32'h4); chk("seq.v1", 32'(IFID_Valid), 32'd1);
        step("seq2"); chk("seq.pc2", PC, 32'h8);
        step("seq3"); chk("seq.pc3", PC, 32'hC);
        step("seq4"); chk("seq.pc4", PC, 32'h10);

        // Unstalled jump
        set_in(0, 1, 2'd2, 32'h40, 0);
        step("jmp");  chk("jmp.pc", PC, 32'h40); chk("jmp.v", 32'(IFID_Valid), 32'd0);
        chk("jmp.cnt", 32'(RedirectCount), 32'd1);
        set_in(0, 0, 2'd0, 32'h0, 0);
        step("jmp+1"); chk("jmp1.v", 32'(IFID_Valid), 32'd1); chk("jmp1.ifpc", IFID_PC, 32'h40);

        // Stalled redirects, youngest wins, counted once
        set_in(1, 1, 2'd0, 32'h80, 0);  step("pend1");
        set_in(1, 1, 2'd1, 32'h100, 0); step("pend2"); chk("pend2.pc", PC, 32'h44);
        set_in(1, 0, 2'd0, 32'h0, 0);   step("pend3");
        set_in(0, 0, 2'd0, 32'h0, 0);   step("pend4");
        chk("pend.pc", PC, 32'h100); chk("pend.cnt", 32'(RedirectCount), 32'd2);

        // Misaligned redirect fault, frozen, then cleared
        set_in(1, 1, 2'd0, 32'h42, 0); step("flt");
        chk("flt.f", 32'(Fault), 32'd1); chk("flt.addr", FaultAddr, 32'h42); chk("flt.pc", PC, 32'h100);
        set_in(0, 1, 2'd2, 32'h300, 0); step("flt.hold1");
        set_in(0, 0, 2'd0, 32'h0, 0);   step("flt.hold2"); chk("flt.frozen", PC, 32'h100);
        set_in(0, 0, 2'd0, 32'h0, 1);   step("clr");
        chk("clr.pc", PC, RESET_PC); chk("clr.f", 32'(Fault), 32'd0); chk("clr.v", 32'(IFID_Valid), 32'd0);
        set_in(0, 0, 2'd0, 32'h0, 0);   step("clr+1");

        // Reserved kind with aligned target also faults
        set_in(1, 1, 2'd3, 32'h50, 0); step("rsvd"); chk("rsvd.addr", FaultAddr, 32'h50);
        set_in(0, 0, 2'd0, 32'h0, 1);  step("rsvd.clr");

        // PC wrap
        set_in(0, 1, 2'd2, 32'hFFFF_FFFC, 0); step("wrap0");
        set_in(0, 0, 2'd0, 32'h0, 0);         step("wrap1");
        chk("wrap.pc", PC, 32'h0); chk("wrap.ifpc4", IFID_PCPlus4, 32'h0);

        // Reset mid-PEND discards the buffered target
        set_in(1, 1, 2'd0, 32'h200, 0); step("rstpend");
        set_in(0, 0, 2'd0, 32'h0, 0);
        apply_reset();
        chk("rstpend.pc", PC, RESET_PC);
        step("rstpend+1"); chk("rstpend.pc1", PC, RESET_PC + 32'd4);

        // Counter saturation
        for (int i = 0; i < 20; i++) begin
            set_in(0, 1, 2'($urandom_range(0, 2)), $urandom & 32'hFFFF_FFFC, 0);
            step("sat");
        end
        chk("sat.cnt", 32'(RedirectCount), CNT_MAX);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            if ($urandom_range(0, 9) != 0) tgt[1:0] = 2'b00;
            set_in(($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 3),
                   2'($urandom_range(0, 3)), tgt, ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 99) == 0) apply_reset();
            else step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
